pdm_mic_frontend: RTL and testbench

Per-microphone PDM-to-PCM front end that drives the array's shared PDM bit clock and converts each mic's 1-bit PDM stream into BIT_WIDTH-bit PCM words. Each channel uses a 3rd-order CIC decimator. It is the producer for the beamformer's `pcm_data_in` bus: one PCM word per mic per output period, flagged by a single-cycle strobe. All channels share one clock divider and one decimation counter, so every mic's word updates on the same cycle.

---
 rtl/pdm_mic_frontend_if.sv | 28 ++
 rtl/pdm_mic_frontend.sv | 128 ++++++++++++
 tb/tb_pdm_mic_frontend.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pdm_mic_frontend_if.sv
// PDM microphone array bus: enable and raw PDM bits in, shared PDM clock
// and per-mic PCM words with a one-cycle update strobe out.
interface pdm_mic_frontend_if #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned NUM_MICS  = 9
);
  logic                 mic_en;
  logic [NUM_MICS-1:0]  pdm_data_in;
  logic                 pdm_clk;
  logic [BIT_WIDTH-1:0] pcm_data_out [NUM_MICS];
  logic                 pcm_valid;

  modport master (
    input  mic_en,
    input  pdm_data_in,
    output pdm_clk,
    output pcm_data_out,
    output pcm_valid
  );

  modport slave (
    output mic_en,
    output pdm_data_in,
    input  pdm_clk,
    input  pcm_data_out,
    input  pcm_valid
  );
endinterface

// File: rtl/pdm_mic_frontend.sv
// Multi-channel PDM-to-PCM front end: one shared PDM clock divider and decimation
// counter, and a 3rd-order CIC decimator per microphone producing offset-binary words.
module pdm_mic_frontend #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned NUM_MICS  = 9,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DECIM     = 64
) (
  input  logic               clk,
  input  logic               rst,
  pdm_mic_frontend_if.master mic_bus_io
);
  localparam int unsigned ACC_W = 3 * $clog2(DECIM) + 2;
  localparam int unsigned PH_W  = $clog2(CLK_DIV);
  localparam int unsigned DC_W  = $clog2(DECIM);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam logic [PH_W-1:0]      PhLast   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]      PhHalf   = PH_W'(CLK_DIV / 2);
  localparam logic [DC_W-1:0]      DcLast   = DC_W'(DECIM - 1);
  localparam logic [BIT_WIDTH-1:0] MidScale = {1'b1, {(BIT_WIDTH - 1){1'b0}}};
  localparam acc_t                 AccPlus  = acc_t'(1);
  localparam acc_t                 AccMinus = '1;

  logic [NUM_MICS-1:0]  sync0_q, sync0_d, sync1_q, sync1_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [DC_W-1:0]      dc_q, dc_d;
  logic [1:0]           warm_q, warm_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic                 pcm_valid_q, pcm_valid_d;
  acc_t                 int1_q [NUM_MICS], int1_d [NUM_MICS];
  acc_t                 int2_q [NUM_MICS], int2_d [NUM_MICS];
  acc_t                 int3_q [NUM_MICS], int3_d [NUM_MICS];
  acc_t                 dly1_q [NUM_MICS], dly1_d [NUM_MICS];
  acc_t                 dly2_q [NUM_MICS], dly2_d [NUM_MICS];
  acc_t                 dly3_q [NUM_MICS], dly3_d [NUM_MICS];
  acc_t                 comb1 [NUM_MICS], comb2 [NUM_MICS], comb3 [NUM_MICS];
  logic [BIT_WIDTH-1:0] pcm_q [NUM_MICS], pcm_d [NUM_MICS];
  logic                 strobe, boundary, emit;

  always_comb begin
    sync0_d     = mic_bus_io.pdm_data_in;
    sync1_d     = sync0_q;
    strobe      = mic_bus_io.mic_en && (ph_q == PhLast);
    boundary    = strobe && (dc_q == DcLast);
    // The first three boundaries only prime the comb delays.
    emit        = boundary && (warm_q == 2'd3);
    pdm_clk_d   = mic_bus_io.mic_en && (ph_q < PhHalf);
    pcm_valid_d = emit;
    ph_d        = (ph_q == PhLast) ? '0 : ph_q + PH_W'(1);
    dc_d        = strobe ? dc_q + DC_W'(1) : dc_q;
    warm_d      = (boundary && (warm_q != 2'd3)) ? warm_q + 2'd1 : warm_q;
    if (!mic_bus_io.mic_en) begin
      ph_d   = '0;
      dc_d   = '0;
      warm_d = '0;
    end

    for (int m = 0; m < int'(NUM_MICS); m++) begin
      int1_d[m] = int1_q[m];
      int2_d[m] = int2_q[m];
      int3_d[m] = int3_q[m];
      if (strobe) begin
        int1_d[m] = int1_q[m] + (sync1_q[m] ? AccPlus : AccMinus);
        int2_d[m] = int2_q[m] + int1_d[m];
        int3_d[m] = int3_q[m] + int2_d[m];
      end
      comb1[m]  = int3_d[m] - dly1_q[m];
      comb2[m]  = comb1[m] - dly2_q[m];
      comb3[m]  = comb2[m] - dly3_q[m];
      dly1_d[m] = boundary ? int3_d[m] : dly1_q[m];
      dly2_d[m] = boundary ? comb1[m] : dly2_q[m];
      dly3_d[m] = boundary ? comb2[m] : dly3_q[m];
      // Top BIT_WIDTH bits of the comb result, MSB flipped to offset binary.
      pcm_d[m]  = emit ? (BIT_WIDTH'(comb3[m] >>> (ACC_W - BIT_WIDTH)) ^ MidScale) : pcm_q[m];
      if (!mic_bus_io.mic_en) begin
        int1_d[m] = '0;
        int2_d[m] = '0;
        int3_d[m] = '0;
        dly1_d[m] = '0;
        dly2_d[m] = '0;
        dly3_d[m] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q     <= '0;
      sync1_q     <= '0;
      ph_q        <= '0;
      dc_q        <= '0;
      warm_q      <= '0;
      pdm_clk_q   <= 1'b0;
      pcm_valid_q <= 1'b0;
      for (int m = 0; m < int'(NUM_MICS); m++) begin
        int1_q[m] <= '0;
        int2_q[m] <= '0;
        int3_q[m] <= '0;
        dly1_q[m] <= '0;
        dly2_q[m] <= '0;
        dly3_q[m] <= '0;
        pcm_q[m]  <= MidScale;
      end
    end else begin
      sync0_q     <= sync0_d;
      sync1_q     <= sync1_d;
      ph_q        <= ph_d;
      dc_q        <= dc_d;
      warm_q      <= warm_d;
      pdm_clk_q   <= pdm_clk_d;
      pcm_valid_q <= pcm_valid_d;
      int1_q      <= int1_d;
      int2_q      <= int2_d;
      int3_q      <= int3_d;
      dly1_q      <= dly1_d;
      dly2_q      <= dly2_d;
      dly3_q      <= dly3_d;
      pcm_q       <= pcm_d;
    end
  end

  assign mic_bus_io.pdm_clk      = pdm_clk_q;
  assign mic_bus_io.pcm_valid    = pcm_valid_q;
  assign mic_bus_io.pcm_data_out = pcm_q;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Scoreboard bench for pdm_mic_frontend: directed PDM patterns with hand-computed
// CIC outputs queued by the stimulus and checked by a monitor on each pcm_valid.
module tb_pdm_mic_frontend;
  localparam int unsigned BW = 8;
  localparam int unsigned NM = 2;
  localparam int unsigned CD = 4;
  localparam int unsigned DC = 8;

  typedef struct packed {
    logic [7:0] m1;
    logic [7:0] m0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mode0 = 0;
  int   mode1 = 0;
  int   k = 0;
  logic prev_valid = 1'b0;
  exp_t mon_e;

  pdm_mic_frontend_if #(.BIT_WIDTH(BW), .NUM_MICS(NM)) bus ();

  pdm_mic_frontend #(
    .BIT_WIDTH(BW),
    .NUM_MICS (NM),
    .CLK_DIV  (CD),
    .DECIM    (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mic_bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] e0, input logic [7:0] e1);
    exp_t e;
    e.m0 = e0;
    e.m1 = e1;
    exp_q.push_back(e);
  endtask

  // Mode 0: constant 0, 1: constant 1, 2: alternating, 3: step 0->1 at sample 48.
  function automatic logic stim_bit(input int mode, input int idx);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return idx[0];
      default: return (idx >= 48);
    endcase
  endfunction

  // Mic model: new bit appears just after each rising pdm_clk edge.
  initial begin
    forever begin
      @(posedge bus.pdm_clk);
      #1;
      bus.pdm_data_in = {stim_bit(mode1, k), stim_bit(mode0, k)};
      k++;
    end
  end

  // Monitor: every strobe must be single-cycle and match the next queued word pair.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pcm_valid === 1'b1) begin
        check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: got pcm %0h/%0h, required no strobe",
                   bus.pcm_data_out[0], bus.pcm_data_out[1]);
        end else begin
          mon_e = exp_q.pop_front();
          check("pcm_mic0", {24'd0, bus.pcm_data_out[0]}, {24'd0, mon_e.m0});
          check("pcm_mic1", {24'd0, bus.pcm_data_out[1]}, {24'd0, mon_e.m1});
        end
      end
      prev_valid = bus.pcm_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d words pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; that cycle becomes cycle 0 of the new run.
  task automatic start_run(input int m0, input int m1);
    mode0           = m0;
    mode1           = m1;
    k               = 0;
    bus.pdm_data_in = {stim_bit(m1, 0), stim_bit(m0, 0)};
    rst             = 1'b0;
    bus.mic_en      = 1'b1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pcm_valid !== 1'b1 && n < limit);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int         n;
    logic [7:0] pat;
    logic       bad;
    bus.mic_en      = 1'b0;
    bus.pdm_data_in = '0;
    repeat (5) @(negedge clk);

    check("rst_pdm_clk", {31'd0, bus.pdm_clk}, 32'd0);
    check("rst_valid", {31'd0, bus.pcm_valid}, 32'd0);
    check("rst_pcm0", {24'd0, bus.pcm_data_out[0]}, 32'h80);
    check("rst_pcm1", {24'd0, bus.pcm_data_out[1]}, 32'h80);
    bus.mic_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_beats_en", {31'd0, bus.pdm_clk}, 32'd0);

    // Full scale: mic0 all ones, mic1 all zeros; clock pattern and strobe timing.
    start_run(1, 0);
    repeat (3) push_exp(8'hC0, 8'h40);
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      pat[7-c] = bus.pdm_clk;
    end
    check("pdm_clk_pattern", {24'd0, pat}, {24'd0, 8'b0110_0110});
    wait_valid(200, n);
    check("first_valid_cycle", 7 + n, 32'd128);
    wait_valid(64, n);
    check("valid_period_a", n, 32'd32);
    wait_valid(64, n);
    check("valid_period_b", n, 32'd32);
    drain(8);

    // Step on mic0 at a period start (sample 48), idle alternating pattern on mic1.
    bus.mic_en = 1'b0;
    repeat (4) @(negedge clk);
    start_run(3, 2);
    repeat (3) push_exp(8'h40, 8'h80);
    push_exp(8'h5E, 8'h80);
    push_exp(8'hB2, 8'h80);
    repeat (2) push_exp(8'hC0, 8'h80);
    drain(400);

    // Enable gap of 50 cycles mid-period.
    repeat (10) @(negedge clk);
    bus.mic_en = 1'b0;
    bad        = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.pdm_clk !== 1'b0 || bus.pcm_valid !== 1'b0) bad = 1'b1;
    end
    check("gap_quiet", {31'd0, bad}, 32'd0);
    check("gap_hold0", {24'd0, bus.pcm_data_out[0]}, 32'hC0);
    check("gap_hold1", {24'd0, bus.pcm_data_out[1]}, 32'h80);
    start_run(1, 0);
    repeat (2) push_exp(8'hC0, 8'h40);
    wait_valid(200, n);
    check("reenable_first_valid", n, 32'd128);
    wait_valid(64, n);
    check("reenable_period", n, 32'd32);

    // Reset one cycle before the next boundary (now at cycle 160 of this run).
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, bus.pcm_valid}, 32'd0);
    check("midrst_pcm0", {24'd0, bus.pcm_data_out[0]}, 32'h80);
    check("midrst_pcm1", {24'd0, bus.pcm_data_out[1]}, 32'h80);
    start_run(1, 0);
    push_exp(8'hC0, 8'h40);
    wait_valid(200, n);
    check("midrst_first_valid", n, 32'd128);
    drain(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
